// File: rtl/hazard_sb.sv
// Pipeline hazard controller: load-use and long-op scoreboard stalls, redirect flushes,
// a redirect that is held across cache-miss freezes, and a data-hazard stall counter.
module hazard_sb #(
  parameter int NUM_RA = 2,
  parameter int AW     = 5,
  parameter int LAT_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 memread_ex,
  input  logic                 rf_we_ex,
  input  logic [AW-1:0]        rf_wa_ex,
  input  logic [NUM_RA*AW-1:0] rf_ra_id,
  input  logic [NUM_RA-1:0]    rf_re_id,
  input  logic                 long_issue_ex,
  input  logic [LAT_W-1:0]     lat_ex,
  input  logic                 npc_sel_ex,
  input  logic                 inst_sram_miss,
  input  logic                 data_sram_miss,
  output logic                 stall_pc,
  output logic                 stall_if1_if2,
  output logic                 stall_if_id,
  output logic                 flush_if1_if2,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 stall_all,
  output logic                 sb_busy,
  output logic [CNT_W-1:0]     hz_cycles
);

  localparam int NREG = 1 << AW;

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] hz_q, hz_d;

  logic             data_hz;
  logic             redirect;
  logic [LAT_W-1:0] lat_eff;
  logic [AW-1:0]    ra;

  assign stall_all = inst_sram_miss | data_sram_miss;
  assign redirect  = (npc_sel_ex | redir_pend_q) & ~stall_all;
  assign lat_eff   = (lat_ex == '0) ? LAT_W'(1) : lat_ex;

  // A counter of 1 means the result is forwardable next cycle, so only >1 stalls.
  always_comb begin
    data_hz = 1'b0;
    ra      = '0;
    for (int i = 0; i < NUM_RA; i++) begin
      ra = rf_ra_id[i*AW +: AW];
      if (rf_re_id[i] && (ra != '0)) begin
        if ((memread_ex && rf_we_ex && (rf_wa_ex == ra)) ||
            (cnt_q[ra] > LAT_W'(1)) ||
            (long_issue_ex && (rf_wa_ex == ra))) begin
          data_hz = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_pc      = 1'b0;
    stall_if1_if2 = 1'b0;
    stall_if_id   = 1'b0;
    flush_if1_if2 = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    if (redirect) begin
      flush_if1_if2 = 1'b1;
      flush_if_id   = 1'b1;
      flush_id_ex   = 1'b1;
    end else if (data_hz && !stall_all) begin
      stall_pc      = 1'b1;
      stall_if1_if2 = 1'b1;
      stall_if_id   = 1'b1;
      flush_id_ex   = 1'b1;
    end
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (cnt_q[r] != '0) sb_busy = 1'b1;
    end
  end

  // A new long issue overwrites the decremented value of the same entry.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (!stall_all) begin
      for (int r = 1; r < NREG; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      if (long_issue_ex && rf_we_ex && (rf_wa_ex != '0)) begin
        cnt_d[rf_wa_ex] = lat_eff;
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    redir_pend_d = redir_pend_q;
    hz_d         = hz_q;
    if (stall_all) begin
      redir_pend_d = redir_pend_q | npc_sel_ex;
    end else begin
      if (redirect) redir_pend_d = 1'b0;
      if (!redirect && data_hz) hz_d = hz_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      redir_pend_q <= 1'b0;
      hz_q         <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      redir_pend_q <= redir_pend_d;
      hz_q         <= hz_d;
    end
  end

  assign hz_cycles = hz_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: a reference model predicts each cycle's outputs,
// which are queued at drive time and popped and compared mid-cycle.
module tb_hazard_sb;

  localparam int AW     = 5;
  localparam int NUM_RA = 2;
  localparam int LAT_W  = 4;
  localparam int CNT_W  = 32;
  localparam int NREG   = 32;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 memread_ex, rf_we_ex, long_issue_ex, npc_sel_ex;
  logic                 inst_sram_miss, data_sram_miss;
  logic [AW-1:0]        rf_wa_ex;
  logic [NUM_RA*AW-1:0] rf_ra_id;
  logic [NUM_RA-1:0]    rf_re_id;
  logic [LAT_W-1:0]     lat_ex;
  logic                 stall_pc, stall_if1_if2, stall_if_id;
  logic                 flush_if1_if2, flush_if_id, flush_id_ex;
  logic                 stall_all, sb_busy;
  logic [CNT_W-1:0]     hz_cycles;

  hazard_sb #(.NUM_RA(NUM_RA), .AW(AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .memread_ex(memread_ex), .rf_we_ex(rf_we_ex), .rf_wa_ex(rf_wa_ex),
    .rf_ra_id(rf_ra_id), .rf_re_id(rf_re_id),
    .long_issue_ex(long_issue_ex), .lat_ex(lat_ex), .npc_sel_ex(npc_sel_ex),
    .inst_sram_miss(inst_sram_miss), .data_sram_miss(data_sram_miss),
    .stall_pc(stall_pc), .stall_if1_if2(stall_if1_if2), .stall_if_id(stall_if_id),
    .flush_if1_if2(flush_if1_if2), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_all(stall_all), .sb_busy(sb_busy), .hz_cycles(hz_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr, we;
    logic [4:0] wa, ra0, ra1;
    logic [1:0] re;
    logic       li;
    logic [3:0] lat;
    logic       npc, im, dm;
  } stim_t;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        sb;
    logic [31:0] hz;
  } exp_t;

  exp_t        expQ[$];
  int          mcnt[NREG];
  bit          mpend;
  logic [31:0] mhz;
  int          total = 0;
  int          bad   = 0;
  stim_t       st;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    mpend = 0;
    mhz   = 0;
  endtask

  // Drives one cycle of stimulus, predicts outputs, checks them mid-cycle, advances the model.
  task automatic applyStimulus(input stim_t s);
    bit   hz, stl, rd, busy;
    int   ra;
    exp_t e, got;
    memread_ex     = s.mr;
    rf_we_ex       = s.we;
    rf_wa_ex       = s.wa;
    rf_ra_id       = {s.ra1, s.ra0};
    rf_re_id       = s.re;
    long_issue_ex  = s.li;
    lat_ex         = s.lat;
    npc_sel_ex     = s.npc;
    inst_sram_miss = s.im;
    data_sram_miss = s.dm;
    hz = 0;
    for (int p = 0; p < 2; p++) begin
      ra = (p == 1) ? int'(s.ra1) : int'(s.ra0);
      if (s.re[p] && ra != 0 &&
          ((s.mr && s.we && int'(s.wa) == ra) || mcnt[ra] >= 2 || (s.li && int'(s.wa) == ra)))
        hz = 1;
    end
    stl  = s.im | s.dm;
    rd   = (s.npc | mpend) & !stl;
    busy = 0;
    for (int r = 0; r < NREG; r++) if (mcnt[r] != 0) busy = 1;
    e.ctl = {!stl && !rd && hz, !stl && !rd && hz, !stl && !rd && hz,
             rd, rd, !stl && (rd || hz), stl};
    e.sb  = busy;
    e.hz  = mhz;
    expQ.push_back(e);
    @(negedge clk);
    if (expQ.size() == 0) begin
      checkOutput("queue_empty", 32'd0, 32'd1);
    end else begin
      got = expQ.pop_front();
      checkOutput("ctl", {25'd0, stall_pc, stall_if1_if2, stall_if_id,
                          flush_if1_if2, flush_if_id, flush_id_ex, stall_all}, {25'd0, got.ctl});
      checkOutput("sb_busy", {31'd0, sb_busy}, {31'd0, got.sb});
      checkOutput("hz_cycles", hz_cycles, got.hz);
    end
    if (stl) begin
      mpend = mpend | s.npc;
    end else begin
      mpend = 0;
      if (!rd && hz) mhz = mhz + 1;
      for (int r = 1; r < NREG; r++) if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
      if (s.li && s.we && s.wa != 0) mcnt[s.wa] = (s.lat == 0) ? 1 : int'(s.lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    stim_t z;
    z = '0;
    for (int i = 0; i < n; i++) applyStimulus(z);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    st = '0;
    rstn = 1'b0;
    memread_ex = 0; rf_we_ex = 0; rf_wa_ex = '0; rf_ra_id = '0; rf_re_id = '0;
    long_issue_ex = 0; lat_ex = '0; npc_sel_ex = 1'b1; inst_sram_miss = 1'b1; data_sram_miss = 0;
    modelReset();
    #3;
    checkOutput("rst_stall_all", {31'd0, stall_all}, 32'd1);
    checkOutput("rst_flush", {29'd0, flush_if1_if2, flush_if_id, flush_id_ex}, 32'd0);
    checkOutput("rst_hz", hz_cycles, 32'd0);
    npc_sel_ex = 0; inst_sram_miss = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Load-use on port 0, then the same with destination x0.
    st = '0; st.mr = 1; st.we = 1; st.wa = 5; st.ra0 = 5; st.re = 2'b01;
    applyStimulus(st);
    st.wa = 0; st.ra0 = 0;
    applyStimulus(st);
    idle(1);

    // Scoreboard: long op to x7 latency 4, port 1 reading x7 throughout.
    st = '0; st.li = 1; st.we = 1; st.wa = 7; st.lat = 4; st.ra1 = 7; st.re = 2'b10;
    applyStimulus(st);
    st.li = 0; st.we = 0; st.wa = 0; st.lat = 0;
    for (int i = 0; i < 6; i++) applyStimulus(st);

    // Redirect beats a scoreboard hit on port 0.
    st = '0; st.li = 1; st.we = 1; st.wa = 4; st.lat = 5;
    applyStimulus(st);
    st = '0; st.ra0 = 4; st.re = 2'b01; st.npc = 1;
    applyStimulus(st);
    st.npc = 0;
    applyStimulus(st);
    idle(5);

    // Redirect arriving during an I-cache miss, npc held high through the freeze.
    st = '0; st.im = 1;
    applyStimulus(st); applyStimulus(st);
    st.npc = 1;
    for (int i = 0; i < 4; i++) applyStimulus(st);
    st = '0;
    applyStimulus(st); applyStimulus(st);

    // Freeze holds the scoreboard; zero latency behaves as one.
    st = '0; st.li = 1; st.we = 1; st.wa = 3; st.lat = 3;
    applyStimulus(st);
    st = '0; st.dm = 1; st.ra0 = 3; st.re = 2'b01;
    for (int i = 0; i < 4; i++) applyStimulus(st);
    st.dm = 0;
    applyStimulus(st); applyStimulus(st);
    st = '0; st.li = 1; st.we = 1; st.wa = 12; st.lat = 0;
    applyStimulus(st);
    st = '0; st.ra1 = 12; st.re = 2'b10;
    applyStimulus(st); applyStimulus(st);

    // WAW: a shorter reissue overwrites a long pending count.
    st = '0; st.li = 1; st.we = 1; st.wa = 6; st.lat = 15;
    applyStimulus(st);
    st.lat = 1;
    applyStimulus(st);
    st = '0; st.ra0 = 6; st.re = 2'b01;
    applyStimulus(st); applyStimulus(st);

    // Async reset with x9 pending and a held redirect.
    st = '0; st.li = 1; st.we = 1; st.wa = 9; st.lat = 5;
    applyStimulus(st);
    st = '0; st.im = 1; st.npc = 1;
    applyStimulus(st);
    npc_sel_ex = 0; inst_sram_miss = 0; long_issue_ex = 0; rf_we_ex = 0; rf_re_id = '0;
    rstn = 1'b0;
    #1;
    checkOutput("arst_sb_busy", {31'd0, sb_busy}, 32'd0);
    checkOutput("arst_flush", {29'd0, flush_if1_if2, flush_if_id, flush_id_ex}, 32'd0);
    checkOutput("arst_hz", hz_cycles, 32'd0);
    modelReset();
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    st = '0; st.ra0 = 9; st.re = 2'b01;
    applyStimulus(st);

    // Random traffic on a small register window.
    for (int i = 0; i < 400; i++) begin
      st.mr  = ($urandom_range(0, 3) == 0);
      st.we  = ($urandom_range(0, 3) != 0);
      st.wa  = 5'($urandom_range(0, 7));
      st.ra0 = 5'($urandom_range(0, 7));
      st.ra1 = 5'($urandom_range(0, 7));
      st.re  = 2'($urandom_range(0, 3));
      st.li  = ($urandom_range(0, 4) == 0);
      st.lat = 4'($urandom_range(0, 15));
      st.npc = ($urandom_range(0, 7) == 0);
      st.im  = ($urandom_range(0, 9) == 0);
      st.dm  = ($urandom_range(0, 9) == 0);
      applyStimulus(st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
